// File: rtl/lsu.sv
// Load/store unit: accepts one core memory request at a time, checks it for
// legality, drives a single-beat bus request with lane-formatted store data and
// byte mask, and returns sign/zero-extended load data with a one-cycle
// completion pulse.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   req_valid/req_ready     core request handshake (ready only while idle)
//   MemRd, MemWr, MemOp     request kind and access format
//   addr, wdata             byte address and right-aligned store data
//   resp_valid/resp_err     completion pulse and error flag
//   rdata                   registered load result
//   bus_valid/bus_ready     bus request handshake
//   bus_we, bus_addr        write flag, word-aligned address
//   bus_wdata, bus_wmask    lane-replicated store data and byte enables
//   bus_rvalid, bus_rdata   read return
module lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [2:0]        MemOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wmask,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q;
  logic [2:0]  op_q;       // access format of the transaction in flight
  logic [1:0]  off_q;      // byte offset within the word, for load extraction
  logic        is_load_q;

  logic              req_err;
  logic              req_noop;
  logic [DATA_W-1:0] fmt_wdata;
  logic [3:0]        fmt_wmask;
  logic [DATA_W-1:0] load_data;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign req_ready = (state_q == StIdle);
  assign req_noop  = !MemRd && !MemWr;

  // Request legality, evaluated on the live inputs in the acceptance cycle.
  // Alignment only matters when the request actually touches memory.
  always_comb begin
    req_err = 1'b0;
    if (MemRd && MemWr) req_err = 1'b1;
    if (MemOp == 3'b011 || MemOp[2:1] == 2'b11) req_err = 1'b1;
    if (MemWr && MemOp[2]) req_err = 1'b1;
    if ((MemRd || MemWr) && MemOp[1:0] == 2'b01 && addr[0]) req_err = 1'b1;
    if ((MemRd || MemWr) && MemOp == 3'b010 && addr[1:0] != 2'b00) req_err = 1'b1;
  end

  // Store lane formatting: replicate the datum across the word and enable
  // only the addressed lanes.
  always_comb begin
    fmt_wdata = wdata;
    fmt_wmask = 4'b1111;
    case (MemOp[1:0])
      2'b00: begin
        fmt_wdata = {4{wdata[7:0]}};
        fmt_wmask = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{wdata[15:0]}};
        fmt_wmask = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        fmt_wdata = wdata;
        fmt_wmask = 4'b1111;
      end
    endcase
    if (!MemWr) fmt_wmask = 4'b0000;
  end

  // Load extraction from the returned word; op_q[2] selects zero extension.
  always_comb begin
    load_data = bus_rdata;
    byte_v    = bus_rdata[{off_q, 3'b000} +: 8];
    half_v    = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q[1:0])
      2'b00:   load_data = op_q[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_data = op_q[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= 3'b000;
      off_q      <= 2'b00;
      is_load_q  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= '0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wmask  <= 4'b0000;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_err || req_noop) begin
              // Error or no-op: complete directly without touching the bus.
              state_q    <= StDone;
              resp_valid <= 1'b1;
              resp_err   <= req_err;
              if (req_err) rdata <= '0;
            end else begin
              state_q   <= StReq;
              op_q      <= MemOp;
              off_q     <= addr[1:0];
              is_load_q <= MemRd;
              bus_valid <= 1'b1;
              bus_we    <= MemWr;
              bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              bus_wdata <= fmt_wdata;
              bus_wmask <= fmt_wmask;
            end
          end
        end
        StReq: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (is_load_q) begin
              state_q <= StWait;
            end else begin
              state_q    <= StDone;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
            end
          end
        end
        StWait: begin
          if (bus_rvalid) begin
            rdata      <= load_data;
            state_q    <= StDone;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of the core and bus sides.
REQ-002 Parameter DATA_W, fixed 32, SHALL set the data width; other values SHALL NOT be supported.
REQ-003 Ports (name, direction, width, meaning) SHALL be as follows; the block SHALL use one clock, and reset SHALL be synchronous and active-low:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- MemRd  in  1  load request.
- MemWr  in  1  store request.
- MemOp  in  3  access format: 000 = byte signed, 001 = half signed, 010 = word, 100 = byte unsigned, 101 = half unsigned.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  error flag, qualified by resp_valid.
- rdata  out  32  load result after extension.
- bus_valid  out  1  bus request valid.
- bus_ready  in  1  bus accepts the request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00}).
- bus_wdata  out  32  lane-replicated store data.
- bus_wmask  out  4  byte-lane write enables.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read word.

Function
REQ-004 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE; req_ready SHALL be 1 only in IDLE.
REQ-005 The block SHALL latch addr, wdata, MemOp, MemRd and MemWr on acceptance (req_valid & req_ready); later input changes SHALL have no effect until the next acceptance.
REQ-006 An accepted request SHALL be classified as an error when any of these holds:
- MemRd and MemWr are both 1.
- MemOp is 011, 110 or 111.
- A store uses MemOp 100 or 101.
- A half access has addr[0]=1.
- A word access has addr[1:0]!=0.
REQ-007 An error request, or a request with MemRd=MemWr=0, SHALL go IDLE->DONE with no bus activity; resp_err SHALL be 1 for an error and 0 for the no-op case.
REQ-008 A valid request SHALL go IDLE->REQ; in REQ, bus_valid=1 and bus_we, bus_addr, bus_wdata and bus_wmask SHALL hold stable until bus_ready=1.
REQ-009 On the REQ handshake, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-010 In WAIT, the block SHALL capture bus_rdata when bus_rvalid=1 and go to DONE; bus_rvalid SHALL be ignored in every state other than WAIT.
REQ-011 In DONE, resp_valid SHALL be 1 for exactly one cycle and the next state SHALL be IDLE.
REQ-012 Store lane formatting:
- Byte: bus_wdata = {4{wdata[7:0]}}, bus_wmask = 0001 << addr[1:0].
- Half: bus_wdata = {2{wdata[15:0]}}, bus_wmask = 0011 << (2*addr[1]).
- Word: bus_wdata = wdata, bus_wmask = 1111.
- Loads: bus_wmask = 0000.
REQ-013 Load extraction SHALL select the byte at lane addr[1:0] or the half at lane addr[1], then sign-extend for MemOp 000/001 or zero-extend for MemOp 100/101; a word load SHALL return bus_rdata unchanged.
REQ-014 rdata SHALL be registered, SHALL update only when a load completes (0 on an error), and SHALL hold its value until the next completion.
REQ-015 Minimum latency from the acceptance cycle to the resp_valid cycle SHALL be:
- Error or no-op: 1 cycle.
- Store with bus_ready=1: 2 cycles.
- Load with bus_ready=1 and bus_rvalid one cycle later: 3 cycles.
REQ-016 Waits SHALL be unbounded; there SHALL be no timeout.
REQ-017 bus_valid SHALL be 0 in IDLE, WAIT and DONE.

Reset
REQ-018 While rst_n=0 at a rising edge, the state SHALL become IDLE and these outputs SHALL reset to 0: resp_valid, resp_err, rdata, bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask.
REQ-019 Reset in REQ or WAIT SHALL abandon the transaction: bus_valid=0 from the next cycle, no resp_valid, and a late bus_rvalid SHALL be ignored.
REQ-020 req_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Verification
REQ-021 Store byte: addr=0x1003, wdata=0x000000AB, MemOp=000, bus_ready=1 -> bus_wdata=0xABABABAB, bus_wmask=1000, bus_addr=0x1000; resp_valid 2 cycles after acceptance with resp_err=0.
REQ-022 Signed half load: addr=0x2002, MemOp=001, bus_rdata=0x8001_1234 -> rdata=0xFFFF8001; the same load with MemOp=101 -> rdata=0x00008001.
REQ-023 Misaligned word: addr=0x3001, MemOp=010, MemRd=1 -> no bus_valid; resp_valid 1 cycle after acceptance with resp_err=1 and rdata=0.
REQ-024 Backpressure: bus_ready low for 5 cycles during a store -> bus_valid and all bus fields stable for 6 cycles; req_ready=0 throughout; exactly one resp_valid pulse.
REQ-025 Reset mid-load: rst_n=0 in WAIT, then bus_rvalid=1 after release -> no resp_valid, rdata=0, req_ready=1.
REQ-026 Illegal request: MemRd=MemWr=1 -> resp_err=1; a store with MemOp=100 -> resp_err=1, with no bus activity in either case.
